cb_updown_count_reg: RTL and testbench
======================================

Name: cb_updown_count_reg

Overview:
- Register and control end of the carry-chain count slices.
- Holds the present count, computes and registers the next count, and closes the loop that the combinational up/down slices leave open.
- Provides synchronous load, cascade carry in and out, terminal-count detection, a wrap-or-saturate policy and a sticky overflow flag.
- Used as the building block for timers, address generators and loop counters in the ECP3 simulation library set.

Parameters:
- WIDTH, 8, count width in bits; legal range 2..32.
- SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.
- RESET_VAL, 0, value loaded into Q by reset; must fit in WIDTH bits.

Ports:
- CK  input  1  clock; all state changes on the rising edge.
- CD  input  1  synchronous active-high reset.
- CE  input  1  clock enable; 0 freezes all state except reset.
- LOAD  input  1  synchronous parallel load.
- D  input  WIDTH  load data.
- CI  input  1  cascade count enable from the lower stage; 1 = count this cycle.
- CON  input  1  direction; 1 = up, 0 = down (same sense as the count slices).
- Q  output  WIDTH  registered present count.
- CO  output  1  combinational cascade carry/borrow out to the next stage.
- TC  output  1  combinational terminal count.
- OVF  output  1  registered sticky overflow/underflow flag.

Behaviour:
- Clocking: one clock (CK); synchronous active-high reset (CD); no asynchronous paths.
- Reset: when CD=1 at a CK edge, Q <= RESET_VAL and OVF <= 0. This holds regardless of CE, LOAD and CI. Reset mid-count discards the count in progress.
- Priority at each edge: CD > (CE=0: hold) > LOAD > count > hold.
- Load: CE=1 and LOAD=1 gives Q <= D and OVF <= 0. CI and CON are ignored in that cycle. Q shows D one cycle after the edge.
- Count: CE=1, LOAD=0 and CI=1.
  - Up (CON=1): Q <= Q+1, modulo 2^WIDTH.
  - Down (CON=0): Q <= Q-1, modulo 2^WIDTH.
  - Latency: one edge per step.
- TC (combinational): TC = CI & ((CON & Q==all-ones) | (~CON & Q==0)). It is independent of CE and LOAD.
- CO: CO = TC & CE & ~LOAD. Chaining CO into the next stage's CI forms a WIDTH*N counter that advances in a single cycle.
- Boundary with SATURATE=0:
  - Up from all-ones: Q <= 0, OVF <= 1.
  - Down from 0: Q <= all-ones, OVF <= 1.
- Boundary with SATURATE=1:
  - At the boundary with TC=1 and counting, Q holds and OVF <= 1.
  - CO still asserts so upper stages can still observe the event.
- OVF is sticky: it is set only by a boundary count and cleared only by CD or LOAD.
- Simultaneous LOAD with a boundary count: the load wins and OVF <= 0.
- Direction change (CON toggled between cycles): takes effect immediately on the next count. There is no pipeline to flush.
- CE=0: Q and OVF hold. TC is still valid and CO is forced to 0.
- Reset states implied for the outputs:
  - Q = RESET_VAL, OVF = 0.
  - TC and CO follow from Q, CI and CON.

Optional Feature:
- Macro: CB_COUNT_LIMIT_EN.
- When defined:
  - An extra input LIMIT [WIDTH-1:0] is added, and the counter becomes modulo LIMIT+1.
  - Up: Q==LIMIT gives Q <= 0 (SATURATE=0) or a hold (SATURATE=1).
  - Down: Q==0 gives Q <= LIMIT (SATURATE=0) or a hold.
  - The TC up-term compares against LIMIT instead of all-ones.
  - Load of D > LIMIT is accepted as-is. Counting up from Q > LIMIT continues to all-ones, then wraps to 0 without TC.
- When undefined: no LIMIT port; the boundaries are 0 and 2^WIDTH-1.

Test Plan:
- Reset and hold: WIDTH=8, RESET_VAL=8'h5A; assert CD for 2 cycles with CE=1, LOAD=1, D=8'hFF -> Q=8'h5A, OVF=0; then CE=0, CI=1 for 5 cycles -> Q stays 8'h5A.
- Up wrap: load 8'hFD, CON=1, CI=1 for 4 cycles -> Q=FE, FF, 00, 01. TC=1 and CO=1 only while Q=FF. OVF rises on the FF->00 edge and stays 1.
- Down saturate: SATURATE=1, load 8'h02, CON=0, CI=1 for 4 cycles -> Q=01, 00, 00, 00. TC=1 from Q=00, OVF=1 after the first hold; then LOAD with D=8'h10 -> Q=10, OVF=0.
- Cascade: two instances, CO(low) -> CI(high), both with CON=1 and CE=1. Start {high,low}=16'h00FF and count 2 cycles -> 16'h0100, 16'h0101. Then CON=0 for 2 cycles -> 16'h0100, 16'h00FF.
- Simultaneous events: Q=8'hFF, CON=1, CI=1, LOAD=1, D=8'h33 -> Q=8'h33 and OVF=0, with CO=0 in that cycle. Next cycle CD=1 together with LOAD=1 -> Q=RESET_VAL.
- CB_COUNT_LIMIT_EN with LIMIT=8'd9: count up from 0 for 12 cycles -> 1..9, 0, 1, 2, with TC=1 at Q=9. Count down from 0 for 1 cycle -> Q=9, OVF=1.

Source files
------------

// File: rtl/cb_updown_count_reg.sv
// Up/down counter register stage with load, cascade carry, terminal count, wrap/saturate policy and sticky OVF.
// Latency: Q/OVF update one CK edge after a load or count; TC and CO are combinational from Q/CI/CON/CE/LOAD.
// Backpressure: no handshake; CE=0 freezes Q/OVF and forces CO low. Optional macro CB_COUNT_LIMIT_EN adds LIMIT.
module cb_updown_count_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             CE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             CI,
    input  logic             CON,
`ifdef CB_COUNT_LIMIT_EN
    input  logic [WIDTH-1:0] LIMIT,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             TC,
    output logic             OVF
);

    logic [WIDTH-1:0] up_bound;
    logic             at_top;
    logic             at_bottom;
    logic [WIDTH-1:0] q_next;
    logic             ovf_next;

`ifdef CB_COUNT_LIMIT_EN
    assign up_bound = LIMIT;
`else
    assign up_bound = '1;
`endif

    // A value loaded above LIMIT never matches at_top, so it runs on to all-ones and wraps silently.
    assign at_top    = (Q == up_bound);
    assign at_bottom = (Q == '0);

    assign TC = CI & ((CON & at_top) | (~CON & at_bottom));
    assign CO = TC & CE & ~LOAD;

    always_comb begin
        q_next   = Q;
        ovf_next = OVF;
        if (LOAD) begin
            q_next   = D;
            ovf_next = 1'b0;
        end else if (CI) begin
            if (TC) begin
                ovf_next = 1'b1;
                if (!SATURATE) begin
                    q_next = CON ? '0 : up_bound;
                end
            end else begin
                q_next = CON ? (Q + WIDTH'(1)) : (Q - WIDTH'(1));
            end
        end
    end

    always_ff @(posedge CK) begin
        if (CD) begin
            Q   <= RESET_VAL;
            OVF <= 1'b0;
        end else if (CE) begin
            Q   <= q_next;
            OVF <= ovf_next;
        end
    end

endmodule

// File: tb/tb_cb_updown_count_reg.sv
// Randomized bench for cb_updown_count_reg: wrap, saturate and a two-stage cascade checked against an integer model.
module tb_cb_updown_count_reg;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic       cd, ce, load, ci, con;
    logic [7:0] d;
`ifdef CB_COUNT_LIMIT_EN
    logic [7:0] limit;
`endif
    logic [7:0] qa, qb;
    logic       coa, tca, ova, cob, tcb, ovb;

    logic        c_cd, c_ce, c_load, c_ci, c_con;
    logic [15:0] c_d;
    logic [7:0]  ql, qh;
    logic        co_l, tc_l, ov_l, co_h, tc_h, ov_h;

    cb_updown_count_reg #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(8'h5A)) u_wrap (
        .CK(CK), .CD(cd), .CE(ce), .LOAD(load), .D(d), .CI(ci), .CON(con),
`ifdef CB_COUNT_LIMIT_EN
        .LIMIT(limit),
`endif
        .Q(qa), .CO(coa), .TC(tca), .OVF(ova)
    );

    cb_updown_count_reg #(.WIDTH(8), .SATURATE(1'b1), .RESET_VAL(8'h5A)) u_sat (
        .CK(CK), .CD(cd), .CE(ce), .LOAD(load), .D(d), .CI(ci), .CON(con),
`ifdef CB_COUNT_LIMIT_EN
        .LIMIT(limit),
`endif
        .Q(qb), .CO(cob), .TC(tcb), .OVF(ovb)
    );

    cb_updown_count_reg #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(8'h00)) u_lo (
        .CK(CK), .CD(c_cd), .CE(c_ce), .LOAD(c_load), .D(c_d[7:0]), .CI(c_ci), .CON(c_con),
`ifdef CB_COUNT_LIMIT_EN
        .LIMIT(8'hFF),
`endif
        .Q(ql), .CO(co_l), .TC(tc_l), .OVF(ov_l)
    );

    cb_updown_count_reg #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(8'h00)) u_hi (
        .CK(CK), .CD(c_cd), .CE(c_ce), .LOAD(c_load), .D(c_d[15:8]), .CI(co_l), .CON(c_con),
`ifdef CB_COUNT_LIMIT_EN
        .LIMIT(8'hFF),
`endif
        .Q(qh), .CO(co_h), .TC(tc_h), .OVF(ov_h)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: plain integers, the cascade is treated as one 16-bit number.
    int ma_q, mb_q, mv;
    bit ma_o, mb_o, mv_o;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int top_val();
`ifdef CB_COUNT_LIMIT_EN
        return int'(limit);
`else
        return 255;
`endif
    endfunction

    function automatic bit m_tc(input int q);
        return ci && ((con && q == top_val()) || (!con && q == 0));
    endfunction

    function automatic bit m_casc_co();
        int lo;
        lo = mv % 256;
        return c_ci && c_ce && !c_load && ((c_con && lo == 255) || (!c_con && lo == 0));
    endfunction

    task automatic m_stage(input bit sat, input int rv, inout int q, inout bit o);
        if (cd) begin
            q = rv;
            o = 1'b0;
        end else if (ce) begin
            if (load) begin
                q = int'(d);
                o = 1'b0;
            end else if (ci) begin
                if (con) begin
                    if (q == top_val()) begin
                        o = 1'b1;
                        if (!sat) q = 0;
                    end else begin
                        q = (q + 1) % 256;
                    end
                end else begin
                    if (q == 0) begin
                        o = 1'b1;
                        if (!sat) q = top_val();
                    end else begin
                        q = q - 1;
                    end
                end
            end
        end
    endtask

    task automatic m_casc();
        if (c_cd) begin
            mv   = 0;
            mv_o = 1'b0;
        end else if (c_ce) begin
            if (c_load) begin
                mv   = int'(c_d);
                mv_o = 1'b0;
            end else if (c_ci) begin
                if (c_con) begin
                    if (mv == 65535) begin mv = 0; mv_o = 1'b1; end
                    else mv = mv + 1;
                end else begin
                    if (mv == 0) begin mv = 65535; mv_o = 1'b1; end
                    else mv = mv - 1;
                end
            end
        end
    endtask

    // Check combinational outputs before the edge, then registered outputs just after it.
    task automatic tick(input string tag);
        #1;
        check_val({tag, ".tc_a"}, tca, m_tc(ma_q));
        check_val({tag, ".co_a"}, coa, m_tc(ma_q) && ce && !load);
        check_val({tag, ".tc_b"}, tcb, m_tc(mb_q));
        check_val({tag, ".co_b"}, cob, m_tc(mb_q) && ce && !load);
        check_val({tag, ".co_lo"}, co_l, m_casc_co());
        @(posedge CK);
        m_stage(1'b0, 8'h5A, ma_q, ma_o);
        m_stage(1'b1, 8'h5A, mb_q, mb_o);
        m_casc();
        #1;
        check_val({tag, ".q_a"}, qa, ma_q);
        check_val({tag, ".ovf_a"}, ova, ma_o);
        check_val({tag, ".q_b"}, qb, mb_q);
        check_val({tag, ".ovf_b"}, ovb, mb_o);
        check_val({tag, ".q16"}, {qh, ql}, mv);
        check_val({tag, ".ovf16"}, ov_h, mv_o);
    endtask

    task automatic set_in(input bit i_cd, input bit i_ce, input bit i_load, input logic [7:0] i_d,
                          input bit i_ci, input bit i_con);
        cd = i_cd; ce = i_ce; load = i_load; d = i_d; ci = i_ci; con = i_con;
    endtask

    logic [7:0] pick8 [6];
    logic [15:0] pick16 [6];

    initial begin
        set_in(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        c_cd = 1'b1; c_ce = 1'b1; c_load = 1'b0; c_d = '0; c_ci = 1'b0; c_con = 1'b1;
`ifdef CB_COUNT_LIMIT_EN
        limit = 8'hFF;
`endif
        @(posedge CK);
        #1;
        ma_q = 8'h5A; mb_q = 8'h5A; ma_o = 1'b0; mb_o = 1'b0; mv = 0; mv_o = 1'b0;

        // Second reset cycle with load pending: reset must still win.
        tick("reset");
        check_val("reset.q_const", qa, 8'h5A);
        check_val("reset.ovf_const", ova, 1'b0);
        c_cd = 1'b0;

        set_in(1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick("hold");
            check_val("hold.q_const", qa, 8'h5A);
        end

        set_in(1'b0, 1'b1, 1'b1, 8'hFD, 1'b0, 1'b1);
        tick("upwrap.load");
        load = 1'b0; ci = 1'b1;
        for (int i = 0; i < 4; i++) tick("upwrap");

        set_in(1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
        tick("dnsat.load");
        load = 1'b0; ci = 1'b1;
        for (int i = 0; i < 4; i++) tick("dnsat");
        check_val("dnsat.q_b_const", qb, 8'h00);
        check_val("dnsat.ovf_b_const", ovb, 1'b1);
        set_in(1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
        tick("dnsat.reload");
        check_val("dnsat.ovf_b_clr", ovb, 1'b0);

        set_in(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
        tick("simul.pre");
        set_in(1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1);
        tick("simul.load");
        check_val("simul.q_const", qa, 8'h33);
        set_in(1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        tick("simul.rst");
        check_val("simul.rst_const", qa, 8'h5A);

        cd = 1'b0; ce = 1'b0;
        c_load = 1'b1; c_d = 16'h00FF; c_ci = 1'b0; c_con = 1'b1;
        tick("casc.load");
        c_load = 1'b0; c_ci = 1'b1;
        tick("casc.up");
        check_val("casc.up_const", {qh, ql}, 16'h0100);
        tick("casc.up");
        c_con = 1'b0;
        tick("casc.dn");
        tick("casc.dn");
        check_val("casc.dn_const", {qh, ql}, 16'h00FF);

`ifdef CB_COUNT_LIMIT_EN
        limit = 8'd9;
        set_in(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        tick("lim.load");
        load = 1'b0; ci = 1'b1;
        for (int i = 0; i < 12; i++) tick("lim.up");
        set_in(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        tick("lim.load0");
        load = 1'b0; ci = 1'b1;
        tick("lim.dn");
        check_val("lim.dn_const", qa, 8'd9);
`endif

        pick8[0] = 8'h00; pick8[1] = 8'h01; pick8[2] = 8'hFE; pick8[3] = 8'hFF;
        pick16[0] = 16'h0000; pick16[1] = 16'h00FF; pick16[2] = 16'hFFFF;
        pick16[3] = 16'hFFFE; pick16[4] = 16'h0100; pick16[5] = 16'h0001;
        for (int n = 0; n < 800; n++) begin
`ifdef CB_COUNT_LIMIT_EN
            if (n % 100 == 0) limit = 8'($urandom_range(1, 254));
            pick8[4] = limit;
`else
            pick8[4] = 8'h80;
`endif
            pick8[5] = 8'($urandom);
            cd   = ($urandom_range(0, 39) == 0);
            ce   = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 11) == 0);
            ci   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) con = ~con;
            d    = pick8[$urandom_range(0, 5)];
            c_cd   = ($urandom_range(0, 59) == 0);
            c_ce   = ($urandom_range(0, 7) != 0);
            c_load = ($urandom_range(0, 15) == 0);
            c_ci   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) c_con = ~c_con;
            c_d    = ($urandom_range(0, 1) == 0) ? pick16[$urandom_range(0, 5)] : 16'($urandom);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
